// File: rtl/snake_move_controller_if.sv
//==============================================================================
// Module      : snake_move_controller_if
// Description : Tick/direction-request inputs and head-state outputs of the
//               snake move controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface snake_move_controller_if;
    logic       restart;
    logic       tick;
    logic       dir_req_valid;
    logic [1:0] dir_req;
    logic       dir_req_ready;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [1:0] dir;
    logic       busy;
    logic       step_done;
    logic       overrun;
    logic       collide;

    modport master (
        output restart, tick, dir_req_valid, dir_req,
        input  dir_req_ready, head_x, head_y, dir, busy, step_done, overrun, collide
    );

    modport slave (
        input  restart, tick, dir_req_valid, dir_req,
        output dir_req_ready, head_x, head_y, dir, busy, step_done, overrun, collide
    );
endinterface

`default_nettype wire

// File: rtl/snake_move_controller.sv
//==============================================================================
// Module      : snake_move_controller
// Description : Advances the snake head one cell per tick on a 32x32 grid using
//               a single shared 5-bit add/subtract datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module snake_move_controller #(
    parameter bit         WRAP      = 1'b1,
    parameter logic [4:0] START_X   = 5'd16,
    parameter logic [4:0] START_Y   = 5'd16,
    parameter logic [1:0] START_DIR = 2'b00
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    snake_move_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_x;
    logic [4:0] r_y;
    logic [4:0] r_result;
    logic       r_edge;
    logic [1:0] r_dir;
    logic [1:0] r_pend;
    logic       r_done;
    logic       r_ovr;
    logic       r_col;

    logic       w_clear;
    logic       w_busy;
    logic [1:0] w_pend_nxt;
    logic [4:0] w_opa;
    logic [4:0] w_opb;
    logic       w_cin;
    logic [5:0] w_sum;
    logic       w_edge;

    assign w_clear = !resetn || bus.restart;
    assign w_busy  = (r_state == S_CALC) || (r_state == S_COMMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        // Reverse check is against the committed heading, never the pending one
        if (bus.dir_req_valid && (r_state != S_HALT) &&
            (bus.dir_req != {~r_dir[1], r_dir[0]}))
            w_pend_nxt = bus.dir_req;

        // dir[0] selects the axis, dir[1] selects subtract (A + ~1 + 1)
        w_opa  = r_dir[0] ? r_y : r_x;
        w_opb  = r_dir[1] ? 5'b11110 : 5'b00001;
        w_cin  = r_dir[1];
        w_sum  = {1'b0, w_opa} + {1'b0, w_opb} + {5'b00000, w_cin};
        w_edge = w_sum[5] ^ r_dir[1];

        case (r_state)
            S_IDLE:   if (bus.tick) w_state_nxt = S_CALC;
            S_CALC:   w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = (r_edge && !WRAP) ? S_HALT : S_IDLE;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state  <= S_IDLE;
            r_x      <= START_X;
            r_y      <= START_Y;
            r_dir    <= START_DIR;
            r_pend   <= START_DIR;
            r_result <= 5'd0;
            r_edge   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_col    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_done  <= 1'b0;
            r_ovr   <= bus.tick && w_busy;
            case (r_state)
                S_IDLE: begin
                    if (bus.tick) r_dir <= w_pend_nxt;
                end
                S_CALC: begin
                    r_result <= w_sum[4:0];
                    r_edge   <= w_edge;
                end
                S_COMMIT: begin
                    r_done <= 1'b1;
                    if (r_edge && !WRAP)
                        r_col <= 1'b1;
                    else if (r_dir[0])
                        r_y <= r_result;
                    else
                        r_x <= r_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.dir_req_ready = (r_state != S_HALT);
    assign bus.head_x        = r_x;
    assign bus.head_y        = r_y;
    assign bus.dir           = r_dir;
    assign bus.busy          = w_busy;
    assign bus.step_done     = r_done;
    assign bus.overrun       = r_ovr;
    assign bus.collide       = r_col;

endmodule

`default_nettype wire

// File: tb/tb_snake_move_controller.sv
//==============================================================================
// Module      : tb_snake_move_controller
// Description : Drives a wrapping and a non-wrapping controller with shared
//               stimulus and compares both against a cell-level game model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_snake_move_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic       restart;
    logic       tick;
    logic       dvalid;
    logic [1:0] dreq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    snake_move_controller_if if_w ();
    snake_move_controller_if if_n ();

    assign if_w.restart = restart;
    assign if_w.tick = tick;
    assign if_w.dir_req_valid = dvalid;
    assign if_w.dir_req = dreq;
    assign if_n.restart = restart;
    assign if_n.tick = tick;
    assign if_n.dir_req_valid = dvalid;
    assign if_n.dir_req = dreq;

    snake_move_controller #(.WRAP(1'b1)) u_wrap (.clk(clk), .resetn(resetn), .bus(if_w));
    snake_move_controller #(.WRAP(1'b0)) u_wall (.clk(clk), .resetn(resetn), .bus(if_n));

    // Game model: steps_left counts the cycles until the pending move lands
    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [1:0] dir;
        logic [1:0] pend;
        logic [1:0] steps_left;
        logic       halted;
        logic       done;
        logic       ovr;
        logic       col;
    } model_t;

    model_t m [2];

    function automatic model_t model_start();
        model_t n;
        n.x = 5'd16; n.y = 5'd16; n.dir = 2'd0; n.pend = 2'd0;
        n.steps_left = 2'd0; n.halted = 1'b0;
        n.done = 1'b0; n.ovr = 1'b0; n.col = 1'b0;
        return n;
    endfunction

    function automatic model_t model_next(model_t s, bit wrap, logic rn, logic rs,
                                          logic tk, logic v, logic [1:0] rq);
        model_t n;
        int nx, ny, rev;
        n = s;
        if (!rn || rs) return model_start();
        n.done = 1'b0;
        n.ovr  = 1'b0;
        rev = (int'(s.dir) + 2) % 4;
        if (!s.halted && v && int'(rq) != rev) n.pend = rq;
        if (s.halted) begin
        end else if (s.steps_left == 0) begin
            if (tk) begin
                n.dir = n.pend;
                n.steps_left = 2'd2;
            end
        end else begin
            if (tk) n.ovr = 1'b1;
            n.steps_left = s.steps_left - 2'd1;
            if (s.steps_left == 2'd1) begin
                n.done = 1'b1;
                nx = int'(s.x);
                ny = int'(s.y);
                case (s.dir)
                    2'd0: nx = nx + 1;
                    2'd1: ny = ny + 1;
                    2'd2: nx = nx - 1;
                    default: ny = ny - 1;
                endcase
                if (!wrap && (nx < 0 || nx > 31 || ny < 0 || ny > 31)) begin
                    n.halted = 1'b1;
                    n.col = 1'b1;
                end else begin
                    n.x = 5'((nx + 32) % 32);
                    n.y = 5'((ny + 32) % 32);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= model_next(m[0], 1'b1, resetn, restart, tick, dvalid, dreq);
        m[1] <= model_next(m[1], 1'b0, resetn, restart, tick, dvalid, dreq);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        check("w.head_x", int'(if_w.head_x), int'(m[0].x));
        check("w.head_y", int'(if_w.head_y), int'(m[0].y));
        check("w.dir", int'(if_w.dir), int'(m[0].dir));
        check("w.busy", int'(if_w.busy), int'(m[0].steps_left != 0));
        check("w.step_done", int'(if_w.step_done), int'(m[0].done));
        check("w.overrun", int'(if_w.overrun), int'(m[0].ovr));
        check("w.collide", int'(if_w.collide), int'(m[0].col));
        check("w.ready", int'(if_w.dir_req_ready), int'(!m[0].halted));
        check("n.head_x", int'(if_n.head_x), int'(m[1].x));
        check("n.head_y", int'(if_n.head_y), int'(m[1].y));
        check("n.dir", int'(if_n.dir), int'(m[1].dir));
        check("n.busy", int'(if_n.busy), int'(m[1].steps_left != 0));
        check("n.step_done", int'(if_n.step_done), int'(m[1].done));
        check("n.overrun", int'(if_n.overrun), int'(m[1].ovr));
        check("n.collide", int'(if_n.collide), int'(m[1].col));
        check("n.ready", int'(if_n.dir_req_ready), int'(!m[1].halted));
    endtask

    task automatic step(input logic rn, input logic rs, input logic tk,
                        input logic v, input logic [1:0] rq);
        resetn = rn; restart = rs; tick = tk; dvalid = v; dreq = rq;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_step(input logic v, input logic [1:0] rq);
        step(1'b1, 1'b0, 1'b1, v, rq);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        m[0] = model_start();
        m[1] = model_start();
        resetn = 1'b0; restart = 1'b0; tick = 1'b0; dvalid = 1'b0; dreq = 2'd0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rst.head_x", int'(if_w.head_x), 16);
        check("rst.head_y", int'(if_w.head_y), 16);
        check("rst.collide", int'(if_n.collide), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        repeat (3) tick_step(1'b0, 2'd0);
        check("three_ticks.x", int'(if_w.head_x), 19);
        check("three_ticks.y", int'(if_w.head_y), 16);

        repeat (12) tick_step(1'b0, 2'd0);
        check("edge.x", int'(if_n.head_x), 31);
        tick_step(1'b0, 2'd0);
        check("wrap.x", int'(if_w.head_x), 0);
        check("wrap.collide", int'(if_w.collide), 0);
        check("wall.x", int'(if_n.head_x), 31);
        check("wall.collide", int'(if_n.collide), 1);
        tick_step(1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        check("restart.x", int'(if_n.head_x), 16);
        check("restart.collide", int'(if_n.collide), 0);

        tick_step(1'b1, 2'b11);
        repeat (16) tick_step(1'b0, 2'd0);
        check("wrap.y", int'(if_w.head_y), 31);
        check("wall_up.collide", int'(if_n.collide), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        step(1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
        tick_step(1'b0, 2'd0);
        check("reverse.dir", int'(if_w.dir), 0);
        check("reverse.x", int'(if_w.head_x), 17);
        tick_step(1'b1, 2'b01);
        check("same_cycle.dir", int'(if_w.dir), 1);
        check("same_cycle.y", int'(if_w.head_y), 17);

        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        check("overrun.pulse", int'(if_w.overrun), 1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        check("overrun.one_step", int'(if_w.head_y), 18);

        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("mid_reset.y", int'(if_w.head_y), 16);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        check("mid_reset.done", int'(if_w.step_done), 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0),
                 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
